prefix_adder_seq: RTL and testbench
===================================

PREFIX_ADDER_SEQ -- requirements
Module: prefix_adder_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand width; legal values are powers of two from 4 to 64.
REQ-002 The block SHALL have derived constant LOG2W = log2(WIDTH), giving the number of prefix stages (4 at default).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port start, input, 1 bit: request an addition, sampled on the rising edge.
REQ-006 The block SHALL have ports a and b, input, WIDTH bits each: operands, sampled with start.
REQ-007 The block SHALL have port cin, input, 1 bit: carry-in, sampled with start.
REQ-008 The block SHALL have port busy, output, 1 bit: high while an operation is in flight.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking sum and cout valid.
REQ-010 The block SHALL have port sum, output, WIDTH bits: registered result.
REQ-011 The block SHALL have port cout, output, 1 bit: registered carry-out.

Function
REQ-012 The block SHALL sequence one row of WIDTH dot cells (Ghl = Gh | Ph&Gl, Phl = Ph&Pl) across LOG2W cycles as an iterative Kogge-Stone prefix adder.
REQ-013 The FSM SHALL have exactly three states: IDLE, PREFIX, FINISH.
REQ-014 In IDLE with start=1, the block SHALL perform the following at that edge:
- latch h = a^b, G[i] = a[i]&b[i], P[i] = a[i]^b[i] for i>0;
- set G[0] = a0&b0 | (a0^b0)&cin and P[0] = 0 (carry-in folded into bit 0);
- latch cin;
- clear stage counter k to 0;
- enter PREFIX.
REQ-015 In PREFIX, each edge SHALL apply stage k:
- for i >= 2^k: G[i] <= G[i] | P[i]&G[i-2^k] and P[i] <= P[i]&P[i-2^k];
- for i < 2^k: G[i] and P[i] are unchanged;
- then k increments.
REQ-016 When k = LOG2W-1, the PREFIX edge SHALL apply the final stage and enter FINISH.
REQ-017 In FINISH, the edge SHALL:
- register sum[0] = h[0]^cin and sum[i] = h[i]^G[i-1];
- register cout = G[WIDTH-1];
- set done=1;
- return to IDLE.
REQ-018 Latency SHALL be fixed: start sampled at edge E0 gives done=1 in the cycle after edge E(LOG2W+1), which is E5 at default.
REQ-019 busy SHALL be 1 exactly while in PREFIX or FINISH, and 0 in IDLE, including the done cycle.
REQ-020 start while busy=1 SHALL be ignored without affecting the in-flight operation or the latched operands.
REQ-021 start asserted in the done cycle SHALL be accepted, giving back-to-back operations one per LOG2W+2 cycles.
REQ-022 done SHALL be high for exactly one cycle per accepted start.
REQ-023 sum and cout SHALL hold their values until the next FINISH edge, and SHALL be unaffected by new starts before that edge.
REQ-024 Operand changes on a, b, or cin while busy SHALL have no effect.
REQ-025 All arithmetic SHALL be modulo 2^WIDTH, with the overflow bit reported only on cout.

Reset
REQ-026 With rst_n=0 at a rising edge, the block SHALL:
- enter IDLE;
- set k=0, busy=0, done=0, sum=0, cout=0;
- clear G, P, and h to 0.
REQ-027 Reset asserted mid-operation SHALL abort the operation with no done pulse, and the block SHALL accept start on the first edge after rst_n returns high.
REQ-028 While rst_n=0, start SHALL be ignored.

Verification
REQ-029 The bench SHALL cover a carry ripple through all bits: a=0xFFFF, b=0x0001, cin=0 -> done after 5 edges, sum=0x0000, cout=1.
REQ-030 The bench SHALL cover no carries: a=0x1234, b=0x4321, cin=0 -> sum=0x5555, cout=0.
REQ-031 The bench SHALL cover carry-in propagation: a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1; and a=0x7FFF, b=0x0000, cin=1 -> sum=0x8000, cout=0.
REQ-032 The bench SHALL cover start while busy: start at E0 with 0x0001+0x0001, then start at E2 with 0xAAAA+0x5555 -> exactly one done, sum=0x0002, and no second done.
REQ-033 The bench SHALL cover back-to-back operation: start held high continuously -> done every 6 cycles, each result matching the operands sampled at its accept edge.
REQ-034 The bench SHALL cover reset mid-operation: rst_n=0 at E3 -> no done pulse, sum=0, busy=0, and a following start of 0x0100+0x0100 -> sum=0x0200.

Source files
------------

// File: rtl/prefix_adder_seq.sv
// Iterative Kogge-Stone adder: one row of WIDTH dot cells reused over LOG2W cycles.
// Operands and carry-in are captured on start; the result is registered in FINISH.
//
// state  | meaning
// IDLE   | waiting for start; sum/cout hold the last result
// PREFIX | applying prefix stage k (span 2^k) to the G/P row
// FINISH | forming sum/cout from h and the final group generates
module prefix_adder_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int LOG2W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PREFIX = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [LOG2W-1:0] k;
  logic [WIDTH-1:0] h, g, p;
  logic [WIDTH-1:0] g_ld, p_ld;
  logic [WIDTH-1:0] g_nx, p_nx;
  logic             cin_q;

  assign busy = (state != IDLE);

  // Carry-in is folded into bit 0's generate, so bit 0 never propagates.
  always_comb begin
    g_ld    = a & b;
    g_ld[0] = (a[0] & b[0]) | ((a[0] ^ b[0]) & cin);
    p_ld    = a ^ b;
    p_ld[0] = 1'b0;
  end

  always_comb begin
    g_nx = g;
    p_nx = p;
    for (int s = 0; s < LOG2W; s++) begin
      if (k == LOG2W'(s)) begin
        for (int i = (1 << s); i < WIDTH; i++) begin
          g_nx[i] = g[i] | (p[i] & g[i - (1 << s)]);
          p_nx[i] = p[i] & p[i - (1 << s)];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = PREFIX;
      PREFIX:  if (k == LOG2W'(LOG2W - 1)) state_nx = FINISH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k     <= '0;
      h     <= '0;
      g     <= '0;
      p     <= '0;
      cin_q <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= (state == FINISH);
      case (state)
        IDLE: begin
          if (start) begin
            h     <= a ^ b;
            g     <= g_ld;
            p     <= p_ld;
            cin_q <= cin;
            k     <= '0;
          end
        end
        PREFIX: begin
          g <= g_nx;
          p <= p_nx;
          k <= k + 1'b1;
        end
        FINISH: begin
          sum  <= h ^ {g[WIDTH-2:0], cin_q};
          cout <= g[WIDTH-1];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prefix_adder_seq.sv
// Self-checking bench for prefix_adder_seq against a plain a+b+cin reference.
module tb_prefix_adder_seq;

  localparam int W   = 16;
  localparam int LAT = $clog2(W) + 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  int errors = 0;
  int checks = 0;

  prefix_adder_seq #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
  );

  always #5 clk = ~clk;

  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
    return {1'b0, x} + {1'b0, y} + (W+1)'(c);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One operation with operand/start noise while busy; checks latency, result, pulse width.
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                       input string name);
    logic [W:0] exp;
    int n;
    exp   = ref_add(x, y, c);
    a     = x;
    b     = y;
    cin   = c;
    start = 1'b1;
    tick();
    n = 0;
    do begin
      a     = W'($urandom);
      b     = W'($urandom);
      cin   = 1'($urandom);
      start = 1'($urandom);
      tick();
      n++;
    end while (!done && n < LAT + 6);
    start = 1'b0;
    checks++;
    if (n !== LAT) begin
      errors++;
      $display("FAIL %s latency: got %0d edges, expected %0d", name, n, LAT);
    end
    checks++;
    if ({cout, sum} !== exp) begin
      errors++;
      $display("FAIL %s result: got cout=%0b sum=%h, expected cout=%0b sum=%h",
               name, cout, sum, exp[W], exp[W-1:0]);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy in done cycle: got %0b, expected 0", name, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0 || {cout, sum} !== exp) begin
      errors++;
      $display("FAIL %s after done: got done=%0b cout=%0b sum=%h, expected done=0 cout=%0b sum=%h",
               name, done, cout, sum, exp[W], exp[W-1:0]);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      start = 1'b1;
      a     = W'($urandom);
      b     = W'($urandom);
      cin   = 1'($urandom);
      tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
        errors++;
        $display("FAIL reset state: got busy=%0b done=%0b sum=%h cout=%0b, expected all 0",
                 busy, done, sum, cout);
      end
    end
    start = 1'b0;
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset start ignored: got busy=%0b, expected 0", busy);
    end
  endtask

  task automatic test_directed;
    do_op(16'hFFFF, 16'h0001, 1'b0, "ripple");
    do_op(16'h1234, 16'h4321, 1'b0, "nocarry");
    do_op(16'hFFFF, 16'h0000, 1'b1, "cin_all");
    do_op(16'h7FFF, 16'h0000, 1'b1, "cin_msb");
  endtask

  task automatic test_random;
    for (int i = 0; i < 20; i++)
      do_op(W'($urandom), W'($urandom), 1'($urandom), "random");
  endtask

  task automatic test_start_while_busy;
    int n;
    int ndone;
    a = 16'h0001; b = 16'h0001; cin = 1'b0; start = 1'b1;
    tick();                                   // E0
    start = 1'b0;
    tick();                                   // E1
    a = 16'hAAAA; b = 16'h5555; start = 1'b1;
    tick();                                   // E2
    start = 1'b0;
    n = 2;
    while (!done && n < LAT + 6) begin
      tick();
      n++;
    end
    checks++;
    if (n !== LAT || sum !== 16'h0002 || cout !== 1'b0) begin
      errors++;
      $display("FAIL busy_start first: got edges=%0d sum=%h cout=%0b, expected edges=%0d sum=0002 cout=0",
               n, sum, cout, LAT);
    end
    ndone = 0;
    for (int i = 0; i < 3 * LAT; i++) begin
      tick();
      if (done) ndone++;
    end
    checks++;
    if (ndone !== 0 || sum !== 16'h0002) begin
      errors++;
      $display("FAIL busy_start second: got dones=%0d sum=%h, expected dones=0 sum=0002", ndone, sum);
    end
  endtask

  task automatic test_back_to_back;
    logic [W:0] expq[$];
    logic [W:0] e;
    int period;
    period = LAT + 1;
    start  = 1'b1;
    for (int j = 0; j < period * 6; j++) begin
      a   = W'($urandom);
      b   = W'($urandom);
      cin = 1'($urandom);
      if (j % period == 0) expq.push_back(ref_add(a, b, cin));
      tick();
      if (j % period == period - 1) begin
        e = expq.pop_front();
        checks++;
        if (done !== 1'b1 || {cout, sum} !== e) begin
          errors++;
          $display("FAIL b2b result edge %0d: got done=%0b cout=%0b sum=%h, expected done=1 cout=%0b sum=%h",
                   j, done, cout, sum, e[W], e[W-1:0]);
        end
      end else begin
        checks++;
        if (done !== 1'b0) begin
          errors++;
          $display("FAIL b2b stray done edge %0d: got %0b, expected 0", j, done);
        end
      end
    end
    start = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid;
    int ndone;
    a = W'($urandom); b = W'($urandom); cin = 1'b1; start = 1'b1;
    tick();                                   // E0
    start = 1'b0;
    tick();                                   // E1
    tick();                                   // E2
    rst_n = 1'b0;
    tick();                                   // E3
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid state: got busy=%0b done=%0b sum=%h cout=%0b, expected all 0",
               busy, done, sum, cout);
    end
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < LAT + 2; i++) begin
      tick();
      if (done) ndone++;
    end
    checks++;
    if (ndone !== 0 || sum !== '0) begin
      errors++;
      $display("FAIL reset_mid abort: got dones=%0d sum=%h, expected dones=0 sum=0000", ndone, sum);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    do_op(16'h0100, 16'h0100, 1'b0, "after_reset");
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
